// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared LSU states, opcodes, byte enables and decode helpers
package load_store_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} lsu_state_t;
  localparam int LSU_TIMEOUT_DEFAULT = 16;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [7:0] ALU_OPERATIONS_LB  = 8'h20;
  localparam logic [7:0] ALU_OPERATIONS_LBU = 8'h21;
  localparam logic [7:0] ALU_OPERATIONS_LH  = 8'h22;
  localparam logic [7:0] ALU_OPERATIONS_LHU = 8'h23;
  localparam logic [7:0] ALU_OPERATIONS_LW  = 8'h24;
  localparam logic [7:0] ALU_OPERATIONS_SB  = 8'h25;
  localparam logic [7:0] ALU_OPERATIONS_SH  = 8'h26;
  localparam logic [7:0] ALU_OPERATIONS_SW  = 8'h27;
  function automatic logic is_load(input logic [7:0] op);
    return op inside {ALU_OPERATIONS_LB, ALU_OPERATIONS_LBU, ALU_OPERATIONS_LH,
                      ALU_OPERATIONS_LHU, ALU_OPERATIONS_LW};
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op inside {ALU_OPERATIONS_SB, ALU_OPERATIONS_SH, ALU_OPERATIONS_SW};
  endfunction
  function automatic logic is_aligned(input logic [7:0] op, input logic [1:0] off);
    return (op inside {ALU_OPERATIONS_LH, ALU_OPERATIONS_LHU, ALU_OPERATIONS_SH}) ? !off[0] :
           (op inside {ALU_OPERATIONS_LW, ALU_OPERATIONS_SW}) ? off == 2'b00 : 1'b1;
  endfunction
endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: load lane extraction/extension and store lane replication
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [7:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [7:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  lb;
  logic [15:0] lh;
  always_comb begin
    lb = ld_rdata[{ld_off, 3'b000} +: 8];
    lh = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_op == ALU_OPERATIONS_LB  ? {{24{lb[7]}}, lb} :
              ld_op == ALU_OPERATIONS_LBU ? {24'b0, lb} :
              ld_op == ALU_OPERATIONS_LH  ? {{16{lh[15]}}, lh} :
              ld_op == ALU_OPERATIONS_LHU ? {16'b0, lh} : ld_rdata;
    st_be = st_op == ALU_OPERATIONS_SB ? BE_BYTE << st_off :
            st_op == ALU_OPERATIONS_SH ? BE_HALF << st_off : BE_WORD;
    st_wdata = st_op == ALU_OPERATIONS_SB ? {4{st_data[7:0]}} :
               st_op == ALU_OPERATIONS_SH ? {2{st_data[15:0]}} : st_data;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bus initiator with alignment check and load timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [7:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic [31:0] reg_data_b,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  lsu_state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] op_q;
  logic [1:0] off_q;
  logic valid_req, aligned, start;
  logic [3:0] st_be;
  logic [31:0] st_wdata, ld_data;
  assign valid_req = (mem_rd_en ^ mem_wr_en) &&
                     (mem_rd_en ? is_load(alu_operation) : is_store(alu_operation));
  assign aligned = is_aligned(alu_operation, alu_result[1:0]);
  assign start = state == IDLE && valid_req && aligned;
  assign lsu_stall = rst_n && (start || state != IDLE);
  assign bus_req = state == REQ;
  lsu_lane_align u_align (
    .st_op(alu_operation), .st_off(alu_result[1:0]), .st_data(reg_data_b),
    .st_be(st_be), .st_wdata(st_wdata),
    .ld_op(op_q), .ld_off(off_q), .ld_rdata(bus_rdata), .ld_data(ld_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      off_q <= '0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      load_data <= '0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      access_fault <= 1'b0;
      misaligned <= state == IDLE && valid_req && !aligned;
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          op_q <= alu_operation;
          off_q <= alu_result[1:0];
          bus_we <= mem_wr_en;
          bus_addr <= {alu_result[31:2], 2'b00};
          bus_be <= st_be;
          bus_wdata <= st_wdata;
        end
        REQ: begin
          cnt <= '0;
          if (bus_gnt) state <= bus_we ? IDLE : WAIT_RSP;
        end
        WAIT_RSP: if (bus_rvalid) begin
          load_data <= ld_data;
          load_valid <= 1'b1;
          state <= IDLE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          load_data <= '0;
          access_fault <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_rd_en = 1'b0, mem_wr_en = 1'b0;
  logic [7:0] alu_operation = '0;
  logic [31:0] alu_result = '0, reg_data_b = '0;
  logic lsu_stall, load_valid, misaligned, access_fault;
  logic [31:0] load_data;
  logic bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  int checks = 0, failures = 0;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .alu_operation(alu_operation), .alu_result(alu_result), .reg_data_b(reg_data_b),
    .lsu_stall(lsu_stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .access_fault(access_fault), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rd, input logic wr, input logic [7:0] op,
                       input logic [31:0] addr, input logic [31:0] b);
    mem_rd_en = rd;
    mem_wr_en = wr;
    alu_operation = op;
    alu_result = addr;
    reg_data_b = b;
    #1;
  endtask
  task automatic idle_in;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, {31'b0, lsu_stall}, 0);
    check({tag, "_req"}, {31'b0, bus_req}, 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_be"}, {28'b0, bus_be}, 0);
    check({tag, "_ld"}, load_data, 0);
    check({tag, "_strb"}, {29'b0, load_valid, misaligned, access_fault}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    issue(1, 0, ALU_OPERATIONS_LW, 32'h100, 0);
    check_quiet("rst");
    tick;
    tick;
    idle_in;
    rst_n = 1'b1;
    // LB 0x103: gnt at once, stray rvalid in REQ ignored, rvalid two cycles after gnt
    issue(1, 0, ALU_OPERATIONS_LB, 32'h103, 0);
    check("lb_stall0", {31'b0, lsu_stall}, 1);
    check("lb_req0", {31'b0, bus_req}, 0);
    tick;
    idle_in;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
    #1;
    check("lb_req1", {31'b0, bus_req}, 1);
    check("lb_addr", bus_addr, 32'h100);
    check("lb_be", {28'b0, bus_be}, 4'hF);
    check("lb_we", {31'b0, bus_we}, 0);
    check("lb_stall1", {31'b0, lsu_stall}, 1);
    tick;
    bus_gnt = 0; bus_rvalid = 0;
    #1;
    check("lb_stall2", {31'b0, lsu_stall}, 1);
    check("lb_novalid", {31'b0, load_valid}, 0);
    check("lb_req2", {31'b0, bus_req}, 0);
    tick;
    bus_rvalid = 1; bus_rdata = 32'h80AABBCC;
    #1;
    check("lb_stall3", {31'b0, lsu_stall}, 1);
    tick;
    bus_rvalid = 0;
    #1;
    check("lb_valid", {31'b0, load_valid}, 1);
    check("lb_data", load_data, 32'hFFFFFF80);
    check("lb_stall4", {31'b0, lsu_stall}, 0);
    tick;
    check("lb_valid_pulse", {31'b0, load_valid}, 0);
    // SH 0x202 with grant delayed three cycles; store data changes underneath
    issue(0, 1, ALU_OPERATIONS_SH, 32'h202, 32'h00001234);
    check("sh_stall0", {31'b0, lsu_stall}, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      idle_in;
      reg_data_b = 32'hFFFFFFFF;
      alu_result = 32'h0;
      #1;
      check("sh_req", {31'b0, bus_req}, 1);
      check("sh_we", {31'b0, bus_we}, 1);
      check("sh_addr", bus_addr, 32'h200);
      check("sh_be", {28'b0, bus_be}, 4'hC);
      check("sh_wdata", bus_wdata, 32'h12341234);
      check("sh_stall", {31'b0, lsu_stall}, 1);
    end
    tick;
    bus_gnt = 1;
    #1;
    check("sh_req_gnt", {31'b0, bus_req}, 1);
    tick;
    bus_gnt = 0;
    #1;
    check("sh_req_done", {31'b0, bus_req}, 0);
    check("sh_stall_done", {31'b0, lsu_stall}, 0);
    // SB 0x7: top lane
    issue(0, 1, ALU_OPERATIONS_SB, 32'h7, 32'h000000A5);
    tick;
    idle_in;
    bus_gnt = 1;
    #1;
    check("sb_be", {28'b0, bus_be}, 4'h8);
    check("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    check("sb_addr", bus_addr, 32'h4);
    tick;
    bus_gnt = 0;
    #1;
    check("sb_done", {31'b0, bus_req}, 0);
    // LW 0x101 misaligned
    issue(1, 0, ALU_OPERATIONS_LW, 32'h101, 0);
    check("mis_stall0", {31'b0, lsu_stall}, 0);
    tick;
    idle_in;
    #1;
    check("mis_strobe", {31'b0, misaligned}, 1);
    check("mis_req", {31'b0, bus_req}, 0);
    check("mis_stall1", {31'b0, lsu_stall}, 0);
    tick;
    check("mis_pulse", {31'b0, misaligned}, 0);
    check("mis_req2", {31'b0, bus_req}, 0);
    // both enables, then load enable with a store code: nothing happens
    issue(1, 1, ALU_OPERATIONS_LB, 32'h0, 0);
    check("both_stall", {31'b0, lsu_stall}, 0);
    tick;
    issue(1, 0, ALU_OPERATIONS_SW, 32'h1, 0);
    check("both_req", {31'b0, bus_req}, 0);
    check("both_mis", {31'b0, misaligned}, 0);
    check("mm_stall", {31'b0, lsu_stall}, 0);
    tick;
    idle_in;
    #1;
    check("mm_req", {31'b0, bus_req}, 0);
    check("mm_mis", {31'b0, misaligned}, 0);
    // LH 0x2 sign extension from the upper half
    issue(1, 0, ALU_OPERATIONS_LH, 32'h2, 0);
    tick;
    idle_in;
    bus_gnt = 1;
    tick;
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h80010000;
    tick;
    bus_rvalid = 0;
    #1;
    check("lh_valid", {31'b0, load_valid}, 1);
    check("lh_data", load_data, 32'hFFFF8001);
    // LHU 0x40 timeout after 16 WAIT_RSP cycles
    issue(1, 0, ALU_OPERATIONS_LHU, 32'h40, 0);
    tick;
    idle_in;
    bus_gnt = 1;
    tick;
    bus_gnt = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("to_wait_stall", {31'b0, lsu_stall}, 1);
      check("to_wait_fault", {31'b0, access_fault}, 0);
      tick;
    end
    check("to_fault", {31'b0, access_fault}, 1);
    check("to_data", load_data, 0);
    check("to_stall", {31'b0, lsu_stall}, 0);
    check("to_novalid", {31'b0, load_valid}, 0);
    bus_rvalid = 1; bus_rdata = 32'h0000FFFF;
    tick;
    bus_rvalid = 0;
    #1;
    check("to_fault_pulse", {31'b0, access_fault}, 0);
    check("to_late_rvalid", {31'b0, load_valid}, 0);
    check("to_late_data", load_data, 0);
    // LW 0x300 with immediate return, then back-to-back LB started in the result cycle
    issue(1, 0, ALU_OPERATIONS_LW, 32'h300, 0);
    tick;
    idle_in;
    bus_gnt = 1;
    tick;
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h12345678;
    tick;
    bus_rvalid = 0;
    issue(1, 0, ALU_OPERATIONS_LB, 32'h310, 0);
    check("b2b_valid", {31'b0, load_valid}, 1);
    check("b2b_data", load_data, 32'h12345678);
    check("b2b_stall", {31'b0, lsu_stall}, 1);
    tick;
    idle_in;
    bus_gnt = 1;
    #1;
    check("b2b_req", {31'b0, bus_req}, 1);
    check("b2b_addr", bus_addr, 32'h310);
    tick;
    bus_gnt = 0;
    #1;
    check("rst_pre_stall", {31'b0, lsu_stall}, 1);
    // reset in WAIT_RSP, then LBU on the first edge after release
    rst_n = 1'b0;
    bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
    #1;
    check_quiet("rst_mid");
    tick;
    bus_rvalid = 0;
    rst_n = 1'b1;
    issue(1, 0, ALU_OPERATIONS_LBU, 32'h1, 0);
    check("lbu_stall0", {31'b0, lsu_stall}, 1);
    check("lbu_req0", {31'b0, bus_req}, 0);
    tick;
    idle_in;
    bus_gnt = 1;
    #1;
    check("lbu_req", {31'b0, bus_req}, 1);
    check("lbu_addr", bus_addr, 32'h0);
    tick;
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h0000FE00;
    tick;
    bus_rvalid = 0;
    #1;
    check("lbu_valid", {31'b0, load_valid}, 1);
    check("lbu_data", load_data, 32'h000000FE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
